instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch unit: the producer side of the 32-bit `IR` interface consumed by the instruction decoder. It generates sequential word addresses from a program counter and fetches words over a req/ack instruction-memory handshake. Fetched words and their addresses are held in a 2-entry prefetch buffer, and the head entry is presented as `IR`/`ir_pc` with a valid/ready handshake toward execute. A redirect input (branch, exception) flushes the buffer and restarts fetch at a new address, discarding any in-flight response.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset.
- `PF_DEPTH`, 2, prefetch buffer entries. Only 2 is verified.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req`  out  1  fetch request; held until acked.
- `imem_addr`  out  32  word address, `[1:0]`=0; stable while `imem_req`=1.
- `imem_ack`  in  1  response valid; sampled only while `imem_req`=1; may rise in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word; valid when `imem_ack`=1.
- `IR`  out  32  head instruction, to decoder; 0 when buffer empty.
- `ir_pc`  out  32  address of `IR`; 0 when empty.
- `ir_valid`  out  1  buffer non-empty.
- `ir_ready`  in  1  execute consumes `IR` when `ir_valid & ir_ready` (pop).
- `redirect`  in  1  flush and restart fetch.
- `redirect_pc`  in  32  new fetch address; bits `[1:0]` forced to 0.

## Operation
- State `fetch_pc` holds the next address to request.
- FSM states:
  - WAIT: no request outstanding.
  - REQ: `imem_req`=1, `imem_addr`=`fetch_pc`.
  - DRAIN: a request is outstanding whose data will be discarded; `imem_req`=1 with the old address.
- WAIT→REQ when `count_next < PF_DEPTH`.
- REQ on ack:
  - Push `{fetch_pc, imem_rdata}` and advance `fetch_pc += 4` (wraps modulo 2^32).
  - Stay in REQ if `count_next < PF_DEPTH`, else go to WAIT.
- `count_next = count + push − pop`.
- Redirect has priority over ack and pop in the same cycle:
  - Buffer cleared (`count`=0); no push.
  - `fetch_pc` ← `{redirect_pc[31:2], 2'b00}`.
- Redirect from WAIT → REQ.
- Redirect from REQ:
  - With `imem_ack`=1 the same cycle: data dropped, next state REQ.
  - With no ack: go to DRAIN.
- Redirect in DRAIN: update `fetch_pc`, stay in DRAIN.
- DRAIN on ack: data dropped, next state REQ.
- Push and pop in the same cycle with `count`=2 cannot occur; the issue rule guarantees at most one outstanding request and free space for it.
- Pop on an empty buffer: ignored.

## Timing
- During `rst`: `imem_req`=0, `imem_addr`=0, `IR`=0, `ir_pc`=0, `ir_valid`=0, `count`=0, state WAIT, `fetch_pc`=`RESET_PC`.
- First cycle after `rst` falls: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Fetch latency: ack in cycle N → `ir_valid`=1 with that word in cycle N+1. No combinational path from `imem_rdata` to `IR`.
- Throughput: zero-wait memory with `ir_ready` held at 1 gives one instruction per cycle, sustained.
- Redirect in cycle N:
  - `ir_valid`=0 in cycle N+1.
  - New address on `imem_addr` in N+1, or after the drained ack if a request was in flight.
  - Target word valid no earlier than N+2.
- `rst` mid-transaction: all state returns to reset values. A late ack after reset is ignored because `imem_req`=0.

## Structure
- Shared `Defines.v` gets:
  - FSM state encodings `FS_WAIT`, `FS_REQ`, `FS_DRAIN`.
  - `` `PC_STEP `` (32'd4).
  - Default `` `RESET_VECTOR ``.
- Sub-module `fetch_fifo`:
  - `PF_DEPTH`-entry, 64-bit `{pc, data}` synchronous FIFO.
  - Signals: push, pop, flush (flush has priority), count, head outputs.
- `instruction_fetch` contains only the FSM, `fetch_pc`, and the issue logic.

## Test plan
- Reset → sequential fetch: `rst` low, zero-wait memory, `ir_ready`=1 → `imem_addr` 0,4,8,… on consecutive cycles; `IR`/`ir_pc` follow one cycle later, one per cycle.
- Backpressure: `ir_ready`=0 → exactly 2 words buffered, then `imem_req`=0. Set `ir_ready`=1 → words 0x0, 0x4 then 0x8 delivered in order with no loss.
- Redirect with in-flight request: memory with 3-cycle ack latency; `redirect`=1 with `redirect_pc`=0x1003 while req for 0x8 outstanding → the 0x8 data never appears on `IR`; the next request is 0x1000; the first valid `ir_pc` is 0x1000.
- Simultaneous events: redirect, ack and pop in the same cycle → buffer empty next cycle, acked word dropped, request to the redirect target issued.
- Wrap-around: redirect to 0xFFFF_FFFC → fetches 0xFFFF_FFFC then 0x0000_0000.
- Reset mid-fetch: assert `rst` while waiting for an ack → `imem_req`=0 and `ir_valid`=0; a late ack is ignored; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
//   Shared definitions for the instruction fetch unit: fetch FSM state
//   encodings, PC step, default reset vector, the prefetch entry layout and a
//   word-alignment helper.
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

  // WAIT : no request outstanding
  // REQ  : request for fetch_pc outstanding, its data will be kept
  // DRAIN: request outstanding whose data will be thrown away (post-redirect)
  typedef enum logic [1:0] {
    FS_WAIT  = 2'd0,
    FS_REQ   = 2'd1,
    FS_DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  // One prefetch buffer entry: instruction address plus fetched word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   DEPTH-entry synchronous FIFO of {pc, data} prefetch entries.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     push/push_entry write an entry (ignored when full without a pop)
//     pop             remove head entry (ignored when empty)
//     flush           empty the FIFO; wins over push and pop
//     count           number of valid entries
//     head            oldest entry, all zeros when empty
// -----------------------------------------------------------------------------
module fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  fetch_entry_t                   push_entry,
  input  logic                           pop,
  input  logic                           flush,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output fetch_entry_t                   head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  // NOTE: storage has no reset; validity is tracked by count alone, and head
  // is gated to zero while empty, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // NOTE: every sequential assignment uses <= so all flops update together
  // from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Producer side of the IR interface. Issues sequential word fetches over a
//   req/ack instruction-memory handshake, buffers up to PF_DEPTH words and
//   presents the oldest as IR/ir_pc with a valid/ready handshake. A redirect
//   flushes the buffer and restarts fetch at redirect_pc (word aligned); a
//   response already in flight is drained and discarded.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     imem_req, imem_addr      fetch request (held until ack), word address
//     imem_ack, imem_rdata     fetch response
//     IR, ir_pc, ir_valid      head instruction toward execute (0 when empty)
//     ir_ready                 execute consumes head when ir_valid & ir_ready
//     redirect, redirect_pc    flush and restart fetch
// -----------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter int          PF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int CNT_W = $clog2(PF_DEPTH + 1);

  fetch_state_t     state;
  logic [31:0]      fetch_pc;
  logic [31:0]      pc_inc;
  logic [31:0]      target;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             issue_ok;
  logic             push;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  // Only a response to a kept request is buffered; redirect drops it.
  assign push       = (state == FS_REQ) && imem_ack && !redirect;
  assign pop        = ir_valid && ir_ready;
  assign push_entry = '{pc: fetch_pc, data: imem_rdata};
  assign pc_inc     = fetch_pc + PC_STEP;
  assign target     = align_word(redirect_pc);

  // NOTE: combinational outputs are assigned on every path (here a single
  // unconditional expression) so no latch is inferred.
  always_comb begin
    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  // A new request may go out only if its word is guaranteed a free slot.
  assign issue_ok = (count_next < CNT_W'(PF_DEPTH));

  fetch_fifo #(
    .DEPTH (PF_DEPTH)
  ) u_fetch_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .count      (count),
    .head       (head)
  );

  assign ir_valid = (count != '0);
  assign IR       = head.data;
  assign ir_pc    = head.pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FS_WAIT;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else if (redirect) begin
      fetch_pc <= target;
      if (state != FS_WAIT && !imem_ack) begin
        // A request is still in flight: keep it stable and discard its data.
        state <= FS_DRAIN;
      end else begin
        // Nothing pending (or the pending one completes now): go straight
        // to the new target. This also covers DRAIN with its ack arriving.
        state     <= FS_REQ;
        imem_req  <= 1'b1;
        imem_addr <= target;
      end
    end else begin
      case (state)
        FS_WAIT: begin
          if (issue_ok) begin
            state     <= FS_REQ;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        FS_REQ: begin
          if (imem_ack) begin
            fetch_pc <= pc_inc;
            if (issue_ok) begin
              imem_addr <= pc_inc;
            end else begin
              state     <= FS_WAIT;
              imem_req  <= 1'b0;
              imem_addr <= '0;
            end
          end
        end
        FS_DRAIN: begin
          if (imem_ack) begin
            state     <= FS_REQ;
            imem_addr <= fetch_pc;
          end
        end
        default: begin
          state     <= FS_WAIT;
          imem_req  <= 1'b0;
          imem_addr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Self-checking bench for instruction_fetch. A behavioural memory answers
//   requests after a programmable number of wait cycles with a word derived
//   from the address. The reference model is the instruction stream itself:
//   the head of the buffer must always be the next sequential address since
//   reset or the last redirect, carrying that address's memory word.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IR;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  int   checks   = 0;
  int   failures = 0;

  int   lat       = 0;
  int   wait_cnt  = 0;
  logic ack_force = 1'b0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC (RESET_PC),
    .PF_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .IR          (IR),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a ^ 32'h5A5A_1234) * 32'h0001_0193) ^ 32'hC001_D00D;
  endfunction

  // Memory responder: ack after 'lat' wait cycles; ack_force injects a stray ack.
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end
  assign imem_ack   = ack_force | (imem_req && (wait_cnt >= lat));
  assign imem_rdata = ack_force ? 32'hDEAD_BEEF : mem_word(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int l, input logic rdy);
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    ack_force   = 1'b0;
    lat         = l;
    ir_ready    = rdy;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({imem_req, ir_valid} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags: req=%b valid=%b expected 0 0", imem_req, ir_valid);
    end
    checks++;
    if ({imem_addr, IR, ir_pc} !== 96'd0) begin
      failures++;
      $display("FAIL reset_values: addr=%h IR=%h pc=%h expected all 0", imem_addr, IR, ir_pc);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      failures++;
      $display("FAIL reset_first_req: req=%b addr=%h expected 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    do_reset(0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
        failures++;
        $display("FAIL seq_addr[%0d]: req=%b addr=%h expected 1 %h", i, imem_req, imem_addr, 32'(4 * i));
      end
      if (i > 0) begin
        checks++;
        if (ir_valid !== 1'b1 || ir_pc !== 32'(4 * (i - 1)) || IR !== mem_word(32'(4 * (i - 1)))) begin
          failures++;
          $display("FAIL seq_ir[%0d]: valid=%b pc=%h IR=%h expected 1 %h %h", i, ir_valid, ir_pc, IR,
                   32'(4 * (i - 1)), mem_word(32'(4 * (i - 1))));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_list [3];
    int          got;
    exp_list[0] = 32'h0; exp_list[1] = 32'h4; exp_list[2] = 32'h8;
    do_reset(0, 1'b0);
    repeat (5) tick();
    checks++;
    if (imem_req !== 1'b0 || ir_valid !== 1'b1 || ir_pc !== 32'h0) begin
      failures++;
      $display("FAIL bp_full: req=%b valid=%b pc=%h expected 0 1 00000000", imem_req, ir_valid, ir_pc);
    end
    ir_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got < 3; c++) begin
      if (ir_valid) begin
        checks++;
        if (ir_pc !== exp_list[got] || IR !== mem_word(exp_list[got])) begin
          failures++;
          $display("FAIL bp_order[%0d]: pc=%h IR=%h expected %h %h", got, ir_pc, IR, exp_list[got],
                   mem_word(exp_list[got]));
        end
        got++;
      end
      tick();
    end
    checks++;
    if (got != 3) begin
      failures++;
      $display("FAIL bp_count: delivered=%0d expected 3", got);
    end
  endtask

  task automatic test_redirect_inflight();
    logic        found;
    logic        have_addr;
    logic        have_pc;
    logic [31:0] first_addr;
    logic [31:0] first_pc;
    logic [31:0] first_ir;
    do_reset(3, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (imem_req && imem_addr == 32'h8 && !imem_ack) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rd_setup: outstanding req for 00000008 seen=0 expected 1");
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_1003;
    tick();
    redirect = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      failures++;
      $display("FAIL rd_drain: valid=%b req=%b addr=%h expected 0 1 00000008", ir_valid, imem_req, imem_addr);
    end
    have_addr = 1'b0; have_pc = 1'b0;
    first_addr = '0; first_pc = '0; first_ir = '0;
    for (int c = 0; c < 40 && !(have_addr && have_pc); c++) begin
      if (!have_addr && imem_req && imem_addr != 32'h8) begin
        have_addr = 1'b1; first_addr = imem_addr;
      end
      if (!have_pc && ir_valid) begin
        have_pc = 1'b1; first_pc = ir_pc; first_ir = IR;
      end
      tick();
    end
    checks++;
    if (!have_addr || first_addr !== 32'h1000) begin
      failures++;
      $display("FAIL rd_new_addr: seen=%b addr=%h expected 1 00001000", have_addr, first_addr);
    end
    checks++;
    if (!have_pc || first_pc !== 32'h1000 || first_ir !== mem_word(32'h1000)) begin
      failures++;
      $display("FAIL rd_first_ir: seen=%b pc=%h IR=%h expected 1 00001000 %h", have_pc, first_pc, first_ir,
               mem_word(32'h1000));
    end
  endtask

  task automatic test_simultaneous();
    do_reset(0, 1'b1);
    repeat (3) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2002;
    #1;
    checks++;
    if (imem_ack !== 1'b1 || ir_valid !== 1'b1) begin
      failures++;
      $display("FAIL sim_setup: ack=%b valid=%b expected 1 1", imem_ack, ir_valid);
    end
    tick();
    redirect = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h2000) begin
      failures++;
      $display("FAIL sim_flush: valid=%b req=%b addr=%h expected 0 1 00002000", ir_valid, imem_req, imem_addr);
    end
    tick();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h2000 || IR !== mem_word(32'h2000)) begin
      failures++;
      $display("FAIL sim_target: valid=%b pc=%h IR=%h expected 1 00002000 %h", ir_valid, ir_pc, IR,
               mem_word(32'h2000));
    end
  endtask

  task automatic test_wrap();
    do_reset(0, 1'b1);
    repeat (2) tick();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_addr0: addr=%h expected fffffffc", imem_addr);
    end
    tick();
    checks++;
    if (ir_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_step: pc=%h addr=%h expected fffffffc 00000000", ir_pc, imem_addr);
    end
    tick();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h0 || IR !== mem_word(32'h0)) begin
      failures++;
      $display("FAIL wrap_ir: valid=%b pc=%h IR=%h expected 1 00000000 %h", ir_valid, ir_pc, IR, mem_word(32'h0));
    end
  endtask

  task automatic test_reset_midfetch();
    do_reset(5, 1'b1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b0 || ir_valid !== 1'b0 || imem_addr !== 32'h0 || IR !== 32'h0) begin
      failures++;
      $display("FAIL rm_reset: req=%b valid=%b addr=%h IR=%h expected 0 0 0 0", imem_req, ir_valid, imem_addr, IR);
    end
    tick();
    rst       = 1'b0;
    ack_force = 1'b1;
    lat       = 0;
    tick();
    ack_force = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      failures++;
      $display("FAIL rm_late_ack: valid=%b req=%b addr=%h expected 0 1 %h", ir_valid, imem_req, imem_addr, RESET_PC);
    end
    tick();
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== RESET_PC || IR !== mem_word(RESET_PC)) begin
      failures++;
      $display("FAIL rm_restart: valid=%b pc=%h IR=%h expected 1 %h %h", ir_valid, ir_pc, IR, RESET_PC,
               mem_word(RESET_PC));
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic        prev_redirect;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    int          pops;
    do_reset(0, 1'b1);
    exp_pc = RESET_PC;
    prev_redirect = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    pops = 0;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if (prev_redirect) begin
        checks++;
        if (ir_valid !== 1'b0) begin
          failures++;
          $display("FAIL rnd_flush[%0d]: valid=%b expected 0", c, ir_valid);
        end
      end
      checks++;
      if (ir_valid === 1'b1) begin
        if (ir_pc !== exp_pc || IR !== mem_word(exp_pc)) begin
          failures++;
          $display("FAIL rnd_head[%0d]: pc=%h IR=%h expected %h %h", c, ir_pc, IR, exp_pc, mem_word(exp_pc));
        end
      end else if (ir_valid !== 1'b0 || IR !== 32'h0 || ir_pc !== 32'h0) begin
        failures++;
        $display("FAIL rnd_empty[%0d]: valid=%b pc=%h IR=%h expected 0 0 0", c, ir_valid, ir_pc, IR);
      end
      if (prev_req && !prev_ack) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          failures++;
          $display("FAIL rnd_hold[%0d]: req=%b addr=%h expected 1 %h", c, imem_req, imem_addr, prev_addr);
        end
      end
      ir_ready = ($urandom_range(0, 9) < 7);
      lat      = $urandom_range(0, 3);
      redirect = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           redirect_pc = $urandom;
      #1;
      prev_redirect = redirect;
      prev_req      = imem_req;
      prev_ack      = imem_ack;
      prev_addr     = imem_addr;
      if (redirect) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (ir_valid && ir_ready) begin
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    redirect = 1'b0;
    checks++;
    if (pops < 100) begin
      failures++;
      $display("FAIL rnd_progress: pops=%0d expected >= 100", pops);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_inflight();
    test_simultaneous();
    test_wrap();
    test_reset_midfetch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
